// File: rtl/fadd_share_ctrl_if.sv
// Request/response bundle between two client issue blocks and the shared
// floating-point adder controller.
//   in0_* / in1_*   : request channels (valid/ready, operands a and b)
//   out0_* / out1_* : response channels (valid/ready, result, overflow flag)
// master : client side (drives requests and response ready)
// slave  : controller side (drives request ready and responses)
interface fadd_share_ctrl_if;
    logic        in0_valid;
    logic        in0_ready;
    logic [31:0] in0_a;
    logic [31:0] in0_b;
    logic        in1_valid;
    logic        in1_ready;
    logic [31:0] in1_a;
    logic [31:0] in1_b;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_res;
    logic        out0_ovf;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_res;
    logic        out1_ovf;

    modport master (
        output in0_valid, in0_a, in0_b, in1_valid, in1_a, in1_b,
        output out0_ready, out1_ready,
        input  in0_ready, in1_ready,
        input  out0_valid, out0_res, out0_ovf, out1_valid, out1_res, out1_ovf
    );

    modport slave (
        input  in0_valid, in0_a, in0_b, in1_valid, in1_a, in1_b,
        input  out0_ready, out1_ready,
        output in0_ready, in1_ready,
        output out0_valid, out0_res, out0_ovf, out1_valid, out1_res, out1_ovf
    );
endinterface

// File: rtl/fadd_share_ctrl.sv
// Shares one combinational single-precision adder between two requesters.
// Round-robin arbitration, one operation in flight, registered operands and
// result, programmable number of execute cycles (multicycle path on fadd).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fadd_share_ctrl_if.slave (two request and two response channels)
//   busy  : high whenever the controller is not idle

// Combinational IEEE-754 single-precision adder, round to nearest even.
// Subnormals are handled; NaN results are the canonical quiet NaN.
// ovf is set when a finite sum rounds past the largest normal number.
module fadd (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        ovf
);
    logic        a_big, sl, ss, up;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [9:0]  el, es, d, e;
    logic [26:0] ml, ms, msh, nrm;
    logic [27:0] sum;
    logic [24:0] rnd;

    // Subnormals use exponent 1 with no hidden bit; three guard bits below lsb.
    function automatic logic [9:0] eff_exp(input logic [31:0] x);
        return {2'b00, (x[30:23] == 8'd0) ? 8'd1 : x[30:23]};
    endfunction

    function automatic logic [26:0] mant(input logic [31:0] x);
        return {x[30:23] != 8'd0, x[22:0], 3'b000};
    endfunction

    always_comb begin
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        a_big = a[30:0] >= b[30:0];
        sl    = a_big ? a[31] : b[31];
        ss    = a_big ? b[31] : a[31];
        el    = a_big ? eff_exp(a) : eff_exp(b);
        es    = a_big ? eff_exp(b) : eff_exp(a);
        ml    = a_big ? mant(a) : mant(b);
        ms    = a_big ? mant(b) : mant(a);

        d = el - es;
        if (d >= 10'd27) begin
            msh = {26'd0, |ms};
        end else begin
            msh    = ms >> d;
            msh[0] = msh[0] | (|(ms & ~(27'h7FFFFFF << d)));
        end

        sum = (sl == ss) ? ({1'b0, ml} + {1'b0, msh}) : ({1'b0, ml} - {1'b0, msh});

        e = el;
        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            e   = el + 10'd1;
        end else begin
            nrm = sum[26:0];
            // left-normalise, stopping at exponent 1 (subnormal result)
            for (int i = 0; i < 26; i++) begin
                if (!nrm[26] && (e > 10'd1)) begin
                    nrm = nrm << 1;
                    e   = e - 10'd1;
                end
            end
        end

        up  = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
        rnd = {1'b0, nrm[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            e = e + 10'd1;
        end

        ovf = 1'b0;
        if (e >= 10'd255) begin
            res = {sl, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (rnd[24]) begin
            res = {sl, e[7:0], 23'd0};
        end else if (!rnd[23]) begin
            res = {sl, 8'd0, rnd[22:0]};
        end else begin
            res = {sl, e[7:0], rnd[22:0]};
        end

        if (sum == 28'd0) begin
            res = {sl & ss, 31'd0};
        end

        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
            res = 32'h7FC0_0000;
            ovf = 1'b0;
        end else if (inf_a) begin
            res = a;
            ovf = 1'b0;
        end else if (inf_b) begin
            res = b;
            ovf = 1'b0;
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; round-robin grant, ready is combinational
// EXEC  | operands held in registers, adder settling for EXEC_CYCLES cycles
// RESP  | result presented on the owner's response channel until accepted
module fadd_share_ctrl #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    fadd_share_ctrl_if.slave bus,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t      state, state_nx;
    logic        owner, last_grant, grant, accept, owner_done;
    logic [3:0]  exec_cnt;
    logic [31:0] op_a, op_b, res_q, fadd_res;
    logic        ovf_q, fadd_ovf;

    fadd u_fadd (
        .a   (op_a),
        .b   (op_b),
        .res (fadd_res),
        .ovf (fadd_ovf)
    );

    always_comb begin
        state_nx       = state;
        grant          = ~last_grant;
        bus.in0_ready  = 1'b0;
        bus.in1_ready  = 1'b0;
        bus.out0_valid = 1'b0;
        bus.out1_valid = 1'b0;
        bus.out0_res   = 32'd0;
        bus.out1_res   = 32'd0;
        bus.out0_ovf   = 1'b0;
        bus.out1_ovf   = 1'b0;

        if (bus.in0_valid && !bus.in1_valid) begin
            grant = 1'b0;
        end else if (bus.in1_valid && !bus.in0_valid) begin
            grant = 1'b1;
        end

        owner_done = owner ? bus.out1_ready : bus.out0_ready;

        case (state)
            IDLE: begin
                bus.in0_ready = bus.in0_valid && !grant;
                bus.in1_ready = bus.in1_valid && grant;
                if (bus.in0_ready || bus.in1_ready) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt == EXEC_LAST) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (owner) begin
                    bus.out1_valid = 1'b1;
                    bus.out1_res   = res_q;
                    bus.out1_ovf   = ovf_q;
                end else begin
                    bus.out0_valid = 1'b1;
                    bus.out0_res   = res_q;
                    bus.out0_ovf   = ovf_q;
                end
                if (owner_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        accept = bus.in0_ready || bus.in1_ready;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            exec_cnt   <= 4'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            res_q      <= 32'd0;
            ovf_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= grant ? bus.in1_a : bus.in0_a;
                op_b       <= grant ? bus.in1_b : bus.in0_b;
                owner      <= grant;
                last_grant <= grant;
                exec_cnt   <= 4'd0;
            end
            if (state == EXEC) begin
                exec_cnt <= exec_cnt + 4'd1;
                if (exec_cnt == EXEC_LAST) begin
                    res_q <= fadd_res;
                    ovf_q <= fadd_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fadd_share_ctrl.sv
module tb_fadd_share_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic busy1, busy4;
    int   n_checks = 0;
    int   n_fail   = 0;

    fadd_share_ctrl_if b1 ();
    fadd_share_ctrl_if b4 ();

    fadd_share_ctrl #(.EXEC_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1),
        .busy  (busy1)
    );

    fadd_share_ctrl #(.EXEC_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4),
        .busy  (busy4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        b1.in0_valid = 1'b0; b1.in0_a = 32'd0; b1.in0_b = 32'd0;
        b1.in1_valid = 1'b0; b1.in1_a = 32'd0; b1.in1_b = 32'd0;
        b1.out0_ready = 1'b0; b1.out1_ready = 1'b0;
        b4.in0_valid = 1'b0; b4.in0_a = 32'd0; b4.in0_b = 32'd0;
        b4.in1_valid = 1'b0; b4.in1_a = 32'd0; b4.in1_b = 32'd0;
        b4.out0_ready = 1'b0; b4.out1_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_all();
        #1;
        check_bit ("rst_busy1", busy1, 1'b0);
        check_bit ("rst_busy4", busy4, 1'b0);
        check_bit ("rst_in0_ready", b1.in0_ready, 1'b0);
        check_bit ("rst_out0_valid", b1.out0_valid, 1'b0);
        check_bit ("rst_out1_valid", b1.out1_valid, 1'b0);
        check_word("rst_out0_res", b1.out0_res, 32'd0);
        check_bit ("rst_out1_ovf", b1.out1_ovf, 1'b0);
        tick();
        rst_n = 1'b1;

        // Contention: both valid, port 0 wins first (1.5+2.5, 3+-1)
        b1.out0_ready = 1'b1; b1.out1_ready = 1'b1;
        b1.in0_valid = 1'b1; b1.in0_a = 32'h3FC00000; b1.in0_b = 32'h40200000;
        b1.in1_valid = 1'b1; b1.in1_a = 32'h40400000; b1.in1_b = 32'hBF800000;
        #1;
        check_bit("cont_c0_in0_ready", b1.in0_ready, 1'b1);
        check_bit("cont_c0_in1_ready", b1.in1_ready, 1'b0);
        tick(); b1.in0_valid = 1'b0; #1;
        check_bit("cont_c1_in1_ready", b1.in1_ready, 1'b0);
        check_bit("cont_c1_busy", busy1, 1'b1);
        tick(); #1;
        check_bit ("cont_c2_out0_valid", b1.out0_valid, 1'b1);
        check_word("cont_c2_out0_res", b1.out0_res, 32'h40800000);
        check_bit ("cont_c2_out0_ovf", b1.out0_ovf, 1'b0);
        check_bit ("cont_c2_out1_valid", b1.out1_valid, 1'b0);
        check_bit ("cont_c2_in1_ready", b1.in1_ready, 1'b0);
        tick(); #1;
        check_bit("cont_c3_out0_valid", b1.out0_valid, 1'b0);
        check_bit("cont_c3_in1_ready", b1.in1_ready, 1'b1);
        check_bit("cont_c3_in0_ready", b1.in0_ready, 1'b0);
        tick(); b1.in1_valid = 1'b0; #1;
        check_bit("cont_c4_out1_valid", b1.out1_valid, 1'b0);
        tick(); #1;
        check_bit ("cont_c5_out1_valid", b1.out1_valid, 1'b1);
        check_word("cont_c5_out1_res", b1.out1_res, 32'h40000000);
        check_word("cont_c5_out0_res", b1.out0_res, 32'd0);
        tick(); #1;
        check_bit("cont_c6_busy", busy1, 1'b0);

        // Fairness: both held valid for 12 cycles -> grants 0,1,0,1
        b1.in0_valid = 1'b1; b1.in0_a = 32'h3F800000; b1.in0_b = 32'h40000000;
        b1.in1_valid = 1'b1; b1.in1_a = 32'h40400000; b1.in1_b = 32'hBF800000;
        for (int i = 0; i < 12; i++) begin
            #1;
            check_bit ($sformatf("fair_in0_ready_%0d", i), b1.in0_ready, (i % 6) == 0);
            check_bit ($sformatf("fair_in1_ready_%0d", i), b1.in1_ready, (i % 6) == 3);
            check_bit ($sformatf("fair_out0_valid_%0d", i), b1.out0_valid, (i % 6) == 2);
            check_bit ($sformatf("fair_out1_valid_%0d", i), b1.out1_valid, (i % 6) == 5);
            check_word($sformatf("fair_out0_res_%0d", i), b1.out0_res,
                       ((i % 6) == 2) ? 32'h40400000 : 32'd0);
            check_word($sformatf("fair_out1_res_%0d", i), b1.out1_res,
                       ((i % 6) == 5) ? 32'h40000000 : 32'd0);
            tick();
        end
        b1.in0_valid = 1'b0; b1.in1_valid = 1'b0;
        #1;
        check_bit("fair_end_busy", busy1, 1'b0);

        // Single request on port 0: 1.0 + 2.0 = 3.0
        b1.in0_valid = 1'b1; b1.in0_a = 32'h3F800000; b1.in0_b = 32'h40000000;
        #1;
        check_bit("single_c0_in0_ready", b1.in0_ready, 1'b1);
        check_bit("single_c0_in1_ready", b1.in1_ready, 1'b0);
        check_bit("single_c0_busy", busy1, 1'b0);
        tick(); b1.in0_valid = 1'b0; #1;
        check_bit("single_c1_busy", busy1, 1'b1);
        check_bit("single_c1_out0_valid", b1.out0_valid, 1'b0);
        check_bit("single_c1_in1_ready", b1.in1_ready, 1'b0);
        tick(); #1;
        check_bit ("single_c2_out0_valid", b1.out0_valid, 1'b1);
        check_word("single_c2_out0_res", b1.out0_res, 32'h40400000);
        check_bit ("single_c2_out0_ovf", b1.out0_ovf, 1'b0);
        check_bit ("single_c2_busy", busy1, 1'b1);
        check_bit ("single_c2_in1_ready", b1.in1_ready, 1'b0);
        tick(); #1;
        check_bit ("single_c3_busy", busy1, 1'b0);
        check_bit ("single_c3_out0_valid", b1.out0_valid, 1'b0);
        check_word("single_c3_out0_res", b1.out0_res, 32'd0);

        // Backpressure on port 1 (1+1=2); port 0 (3+3=6) waits
        b1.out1_ready = 1'b0;
        b1.in1_valid = 1'b1; b1.in1_a = 32'h3F800000; b1.in1_b = 32'h3F800000;
        #1;
        check_bit("bp_c0_in1_ready", b1.in1_ready, 1'b1);
        tick();
        b1.in1_valid = 1'b0;
        b1.in0_valid = 1'b1; b1.in0_a = 32'h40400000; b1.in0_b = 32'h40400000;
        #1;
        check_bit("bp_c1_in0_ready", b1.in0_ready, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_bit ($sformatf("bp_hold_out1_valid_%0d", k), b1.out1_valid, 1'b1);
            check_word($sformatf("bp_hold_out1_res_%0d", k), b1.out1_res, 32'h40000000);
            check_bit ($sformatf("bp_hold_in0_ready_%0d", k), b1.in0_ready, 1'b0);
            tick();
        end
        b1.out1_ready = 1'b1;
        #1;
        check_bit("bp_c7_out1_valid", b1.out1_valid, 1'b1);
        check_bit("bp_c7_in0_ready", b1.in0_ready, 1'b0);
        tick(); #1;
        check_bit("bp_c8_out1_valid", b1.out1_valid, 1'b0);
        check_bit("bp_c8_in0_ready", b1.in0_ready, 1'b1);
        tick(); b1.in0_valid = 1'b0; #1;
        check_bit("bp_c9_busy", busy1, 1'b1);
        tick(); #1;
        check_bit ("bp_c10_out0_valid", b1.out0_valid, 1'b1);
        check_word("bp_c10_out0_res", b1.out0_res, 32'h40C00000);
        tick(); #1;
        check_bit("bp_c11_busy", busy1, 1'b0);

        // Multicycle instance: max+max overflows; operands changed after accept
        b4.out0_ready = 1'b1;
        b4.in0_valid = 1'b1; b4.in0_a = 32'h7F7FFFFF; b4.in0_b = 32'h7F7FFFFF;
        #1;
        check_bit("mc_c0_in0_ready", b4.in0_ready, 1'b1);
        tick();
        b4.in0_valid = 1'b0; b4.in0_a = 32'h3F800000; b4.in0_b = 32'h3F800000;
        for (int j = 1; j < 5; j++) begin
            #1;
            check_bit($sformatf("mc_c%0d_out0_valid", j), b4.out0_valid, 1'b0);
            check_bit($sformatf("mc_c%0d_busy", j), busy4, 1'b1);
            tick();
        end
        #1;
        check_bit ("mc_c5_out0_valid", b4.out0_valid, 1'b1);
        check_word("mc_c5_out0_res", b4.out0_res, 32'h7F800000);
        check_bit ("mc_c5_out0_ovf", b4.out0_ovf, 1'b1);
        tick(); #1;
        check_bit("mc_c6_out0_valid", b4.out0_valid, 1'b0);
        check_bit("mc_c6_out0_ovf", b4.out0_ovf, 1'b0);
        check_bit("mc_c6_busy", busy4, 1'b0);

        // Reset mid-EXEC, then round-robin restarts with port 0
        b1.in0_valid = 1'b1; b1.in0_a = 32'h3F800000; b1.in0_b = 32'h40000000;
        #1;
        check_bit("rme_c0_in0_ready", b1.in0_ready, 1'b1);
        tick(); b1.in0_valid = 1'b0; #1;
        check_bit("rme_c1_busy", busy1, 1'b1);
        #1; rst_n = 1'b0; #1;
        check_bit ("rme_async_busy", busy1, 1'b0);
        check_bit ("rme_async_out0_valid", b1.out0_valid, 1'b0);
        check_word("rme_async_out0_res", b1.out0_res, 32'd0);
        check_bit ("rme_async_in0_ready", b1.in0_ready, 1'b0);
        tick(); #1;
        check_bit("rme_c2_out0_valid", b1.out0_valid, 1'b0);
        check_bit("rme_c2_busy", busy1, 1'b0);
        rst_n = 1'b1;
        tick(); #1;
        check_bit("rme_c3_out0_valid", b1.out0_valid, 1'b0);
        check_bit("rme_c3_busy", busy1, 1'b0);
        tick();
        b1.in0_valid = 1'b1; b1.in0_a = 32'h3F800000; b1.in0_b = 32'h40000000;
        b1.in1_valid = 1'b1; b1.in1_a = 32'h3FC00000; b1.in1_b = 32'h40200000;
        #1;
        check_bit("rme_c4_in0_ready", b1.in0_ready, 1'b1);
        check_bit("rme_c4_in1_ready", b1.in1_ready, 1'b0);
        tick(); b1.in0_valid = 1'b0; #1;
        check_bit("rme_c5_in1_ready", b1.in1_ready, 1'b0);
        tick(); #1;
        check_bit ("rme_c6_out0_valid", b1.out0_valid, 1'b1);
        check_word("rme_c6_out0_res", b1.out0_res, 32'h40400000);
        tick(); #1;
        check_bit("rme_c7_in1_ready", b1.in1_ready, 1'b1);
        tick(); b1.in1_valid = 1'b0;
        tick(); #1;
        check_bit ("rme_c9_out1_valid", b1.out1_valid, 1'b1);
        check_word("rme_c9_out1_res", b1.out1_res, 32'h40800000);
        tick(); #1;
        check_bit("rme_c10_busy", busy1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fadd_share_ctrl.md
Name: fadd_share_ctrl

Overview:
Shares one combinational `fadd` instance between two requester ports (port 0, port 1).
- Round-robin arbitration, one operation in flight.
- Operand and result registers around the datapath.
- Programmable number of execute cycles, so the adder can be timed as a multicycle path.
- Sits between the issue logic of two client blocks and the single floating-point adder.

Parameters:
EXEC_CYCLES, 1, cycles spent in EXEC before the `fadd` output is captured (legal 1..15).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in0_valid  input  1  port 0 request valid
in0_ready  output  1  port 0 request accepted this cycle
in0_a  input  32  port 0 operand a (IEEE single)
in0_b  input  32  port 0 operand b
in1_valid  input  1  port 1 request valid
in1_ready  output  1  port 1 request accepted this cycle
in1_a  input  32  port 1 operand a
in1_b  input  32  port 1 operand b
out0_valid  output  1  port 0 result valid
out0_ready  input  1  port 0 consumer ready
out0_res  output  32  port 0 result
out0_ovf  output  1  port 0 overflow flag from `fadd`
out1_valid  output  1  port 1 result valid
out1_ready  input  1  port 1 consumer ready
out1_res  output  32  port 1 result
out1_ovf  output  1  port 1 overflow flag
busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE; owner = 0; last_grant = 1, so port 0 wins the first contest.
  - exec_cnt = 0; operand registers = 0; result registers = 0.
  - All outputs 0: all valid/ready low, busy low, res = 0, ovf = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one inX_valid is high, grant = X. If both are high, grant = the port not equal to last_grant.
  - inX_ready = (state == IDLE) && inX_valid && (grant == X). This is combinational; at most one ready is high per cycle.
  - On handshake (valid && ready): latch a/b into operand registers, owner = X, last_grant = X, exec_cnt = 0, go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - The `fadd` instance sees only the operand registers.
  - exec_cnt increments each cycle.
  - When exec_cnt == EXEC_CYCLES-1: capture `fadd` res/ovf into result registers and go to RESP.
- RESP:
  - outOWNER_valid = 1; the other port's out_valid = 0.
  - outX_res/outX_ovf show the result registers only while outX_valid is high; otherwise they are 0.
  - On outOWNER_ready, leave for IDLE next cycle. Otherwise hold, with res/ovf stable.
- Latency and throughput:
  - Accept at edge T gives out_valid high from edge T+EXEC_CYCLES+1.
  - Minimum spacing between accepts is EXEC_CYCLES+2 cycles.
- Requester rules (bench obeys, not checked): inX_valid stays high with stable operands until ready. Request inputs are ignored outside IDLE; no ready is given.
- Owner-side backpressure: outX_ready low holds RESP indefinitely. The other port's request waits and is not accepted early.
- Port rules:
  - A port may receive its result and immediately re-request. Round-robin still gives the other port priority if both are valid.
  - outX_ready while outX_valid is low: no effect.
- Reset mid-operation (any state): immediately return to reset values. The in-flight result is discarded and no out_valid is produced.
- Arithmetic: no modification of `fadd` res/ovf. The block forwards them bit-exact.

Test Plan:
- Single request: in0 = {0x3F800000, 0x40000000} at cycle 0, out0_ready = 1, EXEC_CYCLES = 1 → in0_ready high at cycle 0; out0_valid high at cycle 2; out0_res/ovf equal a standalone `fadd` on the same pair; busy high cycles 1-2; in1_ready never high.
- Contention: both valid from cycle 0 with distinct operands, out*_ready = 1 → port 0 accepted cycle 0, port 1 accepted cycle 3; results on out0 at cycle 2 and out1 at cycle 5, each matching its own operands.
- Fairness: both held valid for 12 cycles → grants alternate 0, 1, 0, 1; no port granted twice in a row.
- Backpressure: port 1 request, out1_ready low for 5 cycles after out1_valid → out1_valid/res stable for 5 cycles; a pending in0_valid is not accepted until the cycle after the out1 handshake.
- Multicycle (EXEC_CYCLES = 4): accept at cycle 0 → out0_valid at cycle 5; operands changed on in0_a/in0_b after the accept do not alter the result.
- Reset mid-EXEC: rst_n low at cycle 1 after an accept at cycle 0 → all outputs 0 asynchronously; no out0_valid after release; the next request is granted port 0 first.
